// File: rtl/fetch_queue_pkg.sv
// Core-wide fetch/decode constants and helpers shared by the fetch queue,
// the fetch stage and the decoder.
package fetch_queue_pkg;

  localparam int XLEN        = 32;
  localparam int FETCH_WIDTH = 2;

  // Canonical NOP (addi x0, x0, 0) driven on empty decode slots.
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  // Bit positions within the fetch slot mask.
  localparam int MASK_SLOT0 = 0;
  localparam int MASK_SLOT1 = 1;

  // Number of valid slots in a fetch packet (0..2).
  function automatic logic [1:0] mask_popcount(input logic [FETCH_WIDTH-1:0] m);
    return {1'b0, m[MASK_SLOT0]} + {1'b0, m[MASK_SLOT1]};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle of the fetch queue.
// master = fetch/decode stages, slave = the queue itself.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = fetch_queue_pkg::XLEN
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   fetch_valid_i;
  logic [FETCH_WIDTH-1:0] fetch_mask_i;
  logic [XLEN-1:0]        fetch_pc_i;
  logic [XLEN-1:0]        inst_0_i;
  logic [XLEN-1:0]        inst_1_i;
  logic                   fetch_ready_o;
  logic [1:0]             dec_valid_o;
  logic [XLEN-1:0]        dec_inst_0_o;
  logic [XLEN-1:0]        dec_pc_0_o;
  logic [XLEN-1:0]        dec_inst_1_o;
  logic [XLEN-1:0]        dec_pc_1_o;
  logic [1:0]             dec_consume_i;
  logic [CW-1:0]          count_o;

  modport master (
    output fetch_valid_i, fetch_mask_i, fetch_pc_i, inst_0_i, inst_1_i, dec_consume_i,
    input  fetch_ready_o, dec_valid_o, dec_inst_0_o, dec_pc_0_o, dec_inst_1_o, dec_pc_1_o,
           count_o
  );

  modport slave (
    input  fetch_valid_i, fetch_mask_i, fetch_pc_i, inst_0_i, inst_1_i, dec_consume_i,
    output fetch_ready_o, dec_valid_o, dec_inst_0_o, dec_pc_0_o, dec_inst_1_o, dec_pc_1_o,
           count_o
  );

endinterface

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: DEPTH x {pc, inst}, two write ports,
// two asynchronous read ports. Contents are not reset.
module fetch_queue_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock_i,
  input  logic          we0_i,
  input  logic [AW-1:0] waddr0_i,
  input  logic [W-1:0]  wdata0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] waddr1_i,
  input  logic [W-1:0]  wdata1_i,
  input  logic [AW-1:0] raddr0_i,
  output logic [W-1:0]  rdata0_o,
  input  logic [AW-1:0] raddr1_i,
  output logic [W-1:0]  rdata1_o
);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;

  // Merge both write ports; the queue never targets the same entry twice.
  always_comb begin
    mem_d = mem_q;
    if (we0_i) mem_d[waddr0_i] = wdata0_i;
    if (we1_i) mem_d[waddr1_i] = wdata1_i;
  end

  // Storage register, no reset: entries are only read once counted valid.
  always_ff @(posedge clock_i) begin
    mem_q <= mem_d;
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/fetch_queue.sv
// Compacting 2-in/2-out instruction buffer between fetch and decode.
// Valid fetch slots are packed contiguously at the tail; decode sees the
// two oldest entries and reports how many it took.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = fetch_queue_pkg::XLEN
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          flush_i,
  fetch_queue_if.slave  q_if
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 2 * XLEN;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          fetch_ready;
  logic          push_en;
  logic [1:0]    n_push;
  logic [1:0]    n_pop;
  logic [1:0]    cons_sat;
  logic [1:0]    avail;
  logic          we0, we1;
  logic [EW-1:0] wdata0, wdata1;
  logic [EW-1:0] rdata0, rdata1;
  logic [XLEN-1:0] pc_slot1;

  // Push/pop accounting and slot compaction for this cycle.
  always_comb begin
    // Ready looks only at the registered count: no path from decode.
    fetch_ready = (count_q <= CW'(DEPTH - 2));
    push_en     = q_if.fetch_valid_i & fetch_ready & ~flush_i;
    n_push      = push_en ? mask_popcount(q_if.fetch_mask_i) : 2'd0;
    pc_slot1    = q_if.fetch_pc_i + XLEN'(4);

    // Lowest valid slot lands at tail; slot1 goes to tail+1 only when both valid.
    we0    = push_en & (|q_if.fetch_mask_i);
    wdata0 = q_if.fetch_mask_i[MASK_SLOT0] ? {q_if.fetch_pc_i, q_if.inst_0_i}
                                           : {pc_slot1, q_if.inst_1_i};
    we1    = push_en & (&q_if.fetch_mask_i);
    wdata1 = {pc_slot1, q_if.inst_1_i};

    // Consume of 3 means 2; then saturate to what is actually presented.
    cons_sat = (q_if.dec_consume_i == 2'd3) ? 2'd2 : q_if.dec_consume_i;
    avail    = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
    n_pop    = (cons_sat < avail) ? cons_sat : avail;

    head_d  = head_q + PW'(n_pop);
    tail_d  = tail_q + PW'(n_push);
    count_d = count_q + CW'(n_push) - CW'(n_pop);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer/occupancy registers; reset beats flush (flush handled in _d).
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  fetch_queue_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
    .clock_i  (clock_i),
    .we0_i    (we0),
    .waddr0_i (tail_q),
    .wdata0_i (wdata0),
    .we1_i    (we1),
    .waddr1_i (tail_q + PW'(1)),
    .wdata1_i (wdata1),
    .raddr0_i (head_q),
    .rdata0_o (rdata0),
    .raddr1_i (head_q + PW'(1)),
    .rdata1_o (rdata1)
  );

  // Decode view: invalid slots show NOP at PC 0 so stale entries never leak.
  always_comb begin
    q_if.dec_valid_o[0] = (count_q >= CW'(1));
    q_if.dec_valid_o[1] = (count_q >= CW'(2));
    q_if.dec_inst_0_o   = q_if.dec_valid_o[0] ? rdata0[XLEN-1:0]  : XLEN'(NOP_INST);
    q_if.dec_pc_0_o     = q_if.dec_valid_o[0] ? rdata0[EW-1:XLEN] : '0;
    q_if.dec_inst_1_o   = q_if.dec_valid_o[1] ? rdata1[XLEN-1:0]  : XLEN'(NOP_INST);
    q_if.dec_pc_1_o     = q_if.dec_valid_o[1] ? rdata1[EW-1:XLEN] : '0;
    q_if.fetch_ready_o  = fetch_ready;
    q_if.count_o        = count_q;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, packet compaction, full/ready,
// streaming across pointer wrap with a reference queue, and flush.
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] IKEY = 32'hDEAD_0000;

  logic clock_i = 1'b0;
  logic reset_i;
  logic flush_i;
  int   n_chk  = 0;
  int   n_pass = 0;

  fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) q_if ();

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .flush_i (flush_i),
    .q_if    (q_if)
  );

  always #5 clock_i = ~clock_i;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic idle();
    q_if.fetch_valid_i = 1'b0;
    q_if.fetch_mask_i  = 2'b00;
    q_if.fetch_pc_i    = '0;
    q_if.inst_0_i      = '0;
    q_if.inst_1_i      = '0;
    q_if.dec_consume_i = 2'd0;
    flush_i            = 1'b0;
  endtask

  task automatic drive_pkt(input logic [1:0] mask, input logic [31:0] pc);
    q_if.fetch_valid_i = 1'b1;
    q_if.fetch_mask_i  = mask;
    q_if.fetch_pc_i    = pc;
    q_if.inst_0_i      = pc ^ IKEY;
    q_if.inst_1_i      = (pc + 32'd4) ^ IKEY;
  endtask

  task automatic test_reset();
    idle();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    step();
    n_chk++; if (q_if.dec_valid_o !== 2'b00) $display("FAIL reset_valid got %b exp 00", q_if.dec_valid_o); else n_pass++;
    n_chk++; if (q_if.fetch_ready_o !== 1'b1) $display("FAIL reset_ready got %b exp 1", q_if.fetch_ready_o); else n_pass++;
    n_chk++; if (q_if.count_o !== 4'd0) $display("FAIL reset_count got %0d exp 0", q_if.count_o); else n_pass++;
    n_chk++; if (q_if.dec_inst_0_o !== NOP) $display("FAIL reset_inst0 got %h exp %h", q_if.dec_inst_0_o, NOP); else n_pass++;
    n_chk++; if (q_if.dec_inst_1_o !== NOP) $display("FAIL reset_inst1 got %h exp %h", q_if.dec_inst_1_o, NOP); else n_pass++;
    n_chk++; if (q_if.dec_pc_0_o !== 32'h0) $display("FAIL reset_pc0 got %h exp 0", q_if.dec_pc_0_o); else n_pass++;
  endtask

  task automatic test_push_pair();
    drive_pkt(2'b11, 32'h100);
    step();
    idle();
    n_chk++; if (q_if.dec_valid_o !== 2'b11) $display("FAIL pair_valid got %b exp 11", q_if.dec_valid_o); else n_pass++;
    n_chk++; if (q_if.dec_pc_0_o !== 32'h100) $display("FAIL pair_pc0 got %h exp 100", q_if.dec_pc_0_o); else n_pass++;
    n_chk++; if (q_if.dec_pc_1_o !== 32'h104) $display("FAIL pair_pc1 got %h exp 104", q_if.dec_pc_1_o); else n_pass++;
    n_chk++; if (q_if.dec_inst_0_o !== (32'h100 ^ IKEY)) $display("FAIL pair_inst0 got %h exp %h", q_if.dec_inst_0_o, 32'h100 ^ IKEY); else n_pass++;
    n_chk++; if (q_if.dec_inst_1_o !== (32'h104 ^ IKEY)) $display("FAIL pair_inst1 got %h exp %h", q_if.dec_inst_1_o, 32'h104 ^ IKEY); else n_pass++;
    n_chk++; if (q_if.count_o !== 4'd2) $display("FAIL pair_count got %0d exp 2", q_if.count_o); else n_pass++;
    q_if.dec_consume_i = 2'd2;
    step();
    idle();
    n_chk++; if (q_if.count_o !== 4'd0) $display("FAIL pair_drain got %0d exp 0", q_if.count_o); else n_pass++;
  endtask

  task automatic test_push_slot1();
    drive_pkt(2'b10, 32'h200);
    step();
    idle();
    n_chk++; if (q_if.dec_inst_0_o !== (32'h204 ^ IKEY)) $display("FAIL slot1_inst0 got %h exp %h", q_if.dec_inst_0_o, 32'h204 ^ IKEY); else n_pass++;
    n_chk++; if (q_if.dec_pc_0_o !== 32'h204) $display("FAIL slot1_pc0 got %h exp 204", q_if.dec_pc_0_o); else n_pass++;
    n_chk++; if (q_if.dec_valid_o !== 2'b01) $display("FAIL slot1_valid got %b exp 01", q_if.dec_valid_o); else n_pass++;
    n_chk++; if (q_if.count_o !== 4'd1) $display("FAIL slot1_count got %0d exp 1", q_if.count_o); else n_pass++;
    n_chk++; if (q_if.dec_pc_1_o !== 32'h0) $display("FAIL slot1_pc1 got %h exp 0", q_if.dec_pc_1_o); else n_pass++;
    // Consume 3 acts as 2, then saturates to the single valid entry.
    q_if.dec_consume_i = 2'd3;
    step();
    idle();
    n_chk++; if (q_if.count_o !== 4'd0) $display("FAIL slot1_sat got %0d exp 0", q_if.count_o); else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 3; i++) begin
      drive_pkt(2'b11, 32'h400 + 32'(i) * 32'd8);
      step();
    end
    drive_pkt(2'b01, 32'h418);
    step();
    idle();
    n_chk++; if (q_if.count_o !== 4'd7) $display("FAIL fill_count got %0d exp 7", q_if.count_o); else n_pass++;
    n_chk++; if (q_if.fetch_ready_o !== 1'b0) $display("FAIL fill_ready got %b exp 0", q_if.fetch_ready_o); else n_pass++;
    drive_pkt(2'b11, 32'h800);
    step();
    idle();
    n_chk++; if (q_if.count_o !== 4'd7) $display("FAIL fill_ignored got %0d exp 7", q_if.count_o); else n_pass++;
    n_chk++; if (q_if.dec_pc_0_o !== 32'h400) $display("FAIL fill_head got %h exp 400", q_if.dec_pc_0_o); else n_pass++;
    q_if.dec_consume_i = 2'd2;
    step();
    idle();
    n_chk++; if (q_if.fetch_ready_o !== 1'b1) $display("FAIL fill_ready_back got %b exp 1", q_if.fetch_ready_o); else n_pass++;
    n_chk++; if (q_if.count_o !== 4'd5) $display("FAIL fill_count5 got %0d exp 5", q_if.count_o); else n_pass++;
    n_chk++; if (q_if.dec_pc_0_o !== 32'h408) $display("FAIL fill_head2 got %h exp 408", q_if.dec_pc_0_o); else n_pass++;
    // Drain 5 -> 3 -> 1 -> 0 (last consume saturates).
    q_if.dec_consume_i = 2'd2;
    for (int i = 0; i < 3; i++) step();
    idle();
    n_chk++; if (q_if.count_o !== 4'd0) $display("FAIL fill_drain got %0d exp 0", q_if.count_o); else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] q[$];
    logic [1:0]  masks[5] = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b00};
    int          k   = 0;
    int          cyc = 0;
    int          npop;
    logic [1:0]  m;
    logic [31:0] pc;
    logic        exp_rdy;
    while ((k < 20 || q.size() > 0) && cyc < 200) begin
      m  = masks[k % 5];
      pc = 32'h1000 + 32'(k) * 32'd8;
      if (k < 20) drive_pkt(m, pc);
      else        q_if.fetch_valid_i = 1'b0;
      q_if.dec_consume_i = (cyc % 2 == 1) ? 2'd2 : 2'd1;
      exp_rdy = (q.size() <= DEPTH - 2);
      n_chk++; if (q_if.fetch_ready_o !== exp_rdy) $display("FAIL stream_ready cyc %0d got %b exp %b", cyc, q_if.fetch_ready_o, exp_rdy); else n_pass++;
      npop = (q.size() < 2) ? q.size() : 2;
      if (int'(q_if.dec_consume_i) < npop) npop = int'(q_if.dec_consume_i);
      step();
      for (int i = 0; i < npop; i++) void'(q.pop_front());
      if (k < 20 && exp_rdy) begin
        if (m[0]) q.push_back(pc);
        if (m[1]) q.push_back(pc + 32'd4);
        k++;
      end
      n_chk++; if (int'(q_if.count_o) !== q.size()) $display("FAIL stream_count cyc %0d got %0d exp %0d", cyc, q_if.count_o, q.size()); else n_pass++;
      if (q.size() >= 1) begin
        n_chk++; if (q_if.dec_pc_0_o !== q[0]) $display("FAIL stream_pc0 cyc %0d got %h exp %h", cyc, q_if.dec_pc_0_o, q[0]); else n_pass++;
        n_chk++; if (q_if.dec_inst_0_o !== (q[0] ^ IKEY)) $display("FAIL stream_inst0 cyc %0d got %h exp %h", cyc, q_if.dec_inst_0_o, q[0] ^ IKEY); else n_pass++;
      end
      if (q.size() >= 2) begin
        n_chk++; if (q_if.dec_pc_1_o !== q[1]) $display("FAIL stream_pc1 cyc %0d got %h exp %h", cyc, q_if.dec_pc_1_o, q[1]); else n_pass++;
      end
      cyc++;
    end
    n_chk++; if (cyc >= 200) $display("FAIL stream_timeout got %0d cycles exp < 200", cyc); else n_pass++;
    idle();
  endtask

  task automatic test_flush();
    drive_pkt(2'b11, 32'h500); step();
    drive_pkt(2'b11, 32'h508); step();
    drive_pkt(2'b01, 32'h510); step();
    idle();
    n_chk++; if (q_if.count_o !== 4'd5) $display("FAIL flush_pre got %0d exp 5", q_if.count_o); else n_pass++;
    drive_pkt(2'b11, 32'h600);
    q_if.dec_consume_i = 2'd2;
    flush_i = 1'b1;
    step();
    idle();
    n_chk++; if (q_if.count_o !== 4'd0) $display("FAIL flush_count got %0d exp 0", q_if.count_o); else n_pass++;
    n_chk++; if (q_if.dec_valid_o !== 2'b00) $display("FAIL flush_valid got %b exp 00", q_if.dec_valid_o); else n_pass++;
    // Consume on empty must not underflow.
    q_if.dec_consume_i = 2'd2;
    step();
    idle();
    n_chk++; if (q_if.count_o !== 4'd0) $display("FAIL empty_consume got %0d exp 0", q_if.count_o); else n_pass++;
    drive_pkt(2'b11, 32'h300);
    step();
    idle();
    n_chk++; if (q_if.dec_pc_0_o !== 32'h300) $display("FAIL flush_head got %h exp 300", q_if.dec_pc_0_o); else n_pass++;
    n_chk++; if (q_if.dec_pc_1_o !== 32'h304) $display("FAIL flush_head1 got %h exp 304", q_if.dec_pc_1_o); else n_pass++;
    n_chk++; if (q_if.count_o !== 4'd2) $display("FAIL flush_count2 got %0d exp 2", q_if.count_o); else n_pass++;
  endtask

  initial begin
    reset_i = 1'b1;
    idle();
    test_reset();
    test_push_pair();
    test_push_slot1();
    test_fill();
    test_stream();
    test_flush();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
